// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream boot loader that fills the instruction memory word by word
// Holds the CPU in reset while little-endian byte quadruples are written as 32-bit words.
module imem_loader #(
   parameter int addr_ins_width = 32,
   parameter int memory_width   = 32,
   parameter int memory_height  = 512
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [9:0]                word_count,
   input  logic                      byte_valid,
   input  logic [7:0]                byte_data,
   output logic                      byte_ready,
   output logic                      wr_en,
   output logic [addr_ins_width-1:0] wr_addr,
   output logic [memory_width-1:0]   wr_data,
   output logic                      busy,
   output logic                      done,
   output logic                      error,
   output logic                      cpu_hold
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [10:0] max_words = 11'(memory_height);

   state_t      state;
   logic [1:0]  byte_cnt;
   logic [9:0]  word_idx;
   logic [9:0]  last_idx;
   logic [23:0] asm_word;

   logic start_zero;
   logic start_big;

   assign start_zero = (word_count == 10'd0);
   assign start_big  = ({1'b0, word_count} > max_words);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         byte_cnt   <= 2'd0;
         word_idx   <= 10'd0;
         last_idx   <= 10'd0;
         asm_word   <= 24'd0;
         byte_ready <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         cpu_hold   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  if (start_zero) begin
                     state <= DONE;
                     done  <= 1'b1;
                     error <= 1'b0;
                  end else if (start_big) begin
                     state <= IDLE;
                     done  <= 1'b0;
                     error <= 1'b1;
                  end else begin
                     state      <= LOAD;
                     last_idx   <= word_count - 10'd1;
                     word_idx   <= 10'd0;
                     byte_cnt   <= 2'd0;
                     asm_word   <= 24'd0;
                     done       <= 1'b0;
                     error      <= 1'b0;
                     busy       <= 1'b1;
                     cpu_hold   <= 1'b1;
                     byte_ready <= 1'b1;
                  end
               end
            end

            // byte_ready is always high here, so byte_valid alone means acceptance
            LOAD: begin
               if (byte_valid) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  case (byte_cnt)
                     2'd0: asm_word[7:0]   <= byte_data;
                     2'd1: asm_word[15:8]  <= byte_data;
                     2'd2: asm_word[23:16] <= byte_data;
                     2'd3: begin
                        wr_data    <= {byte_data, asm_word};
                        wr_addr    <= addr_ins_width'(word_idx);
                        wr_en      <= 1'b1;
                        byte_ready <= 1'b0;
                        state      <= WRITE;
                     end
                  endcase
               end
            end

            WRITE: begin
               wr_en <= 1'b0;
               if (word_idx == last_idx) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  cpu_hold <= 1'b0;
               end else begin
                  state      <= LOAD;
                  word_idx   <= word_idx + 10'd1;
                  byte_ready <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
// Decision table for start handling, directed load scenarios and randomized loads vs. a word model.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [9:0]  word_count;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic        error;
   logic        cpu_hold;

   imem_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .word_count (word_count),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .cpu_hold   (cpu_hold)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // write monitor acts as the instruction memory
   logic [31:0] w_addr_q[$];
   logic [31:0] w_data_q[$];
   int          w_cyc_q[$];
   logic [31:0] imem[int];
   int          busy_cycles = 0;

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         w_addr_q.push_back(wr_addr);
         w_data_q.push_back(wr_data);
         w_cyc_q.push_back(cyc);
         imem[int'(wr_addr)] = wr_data;
      end
      if (busy === 1'b1) busy_cycles = busy_cycles + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef logic [7:0] byte_q_t[$];

   logic [31:0] ref_mem[int];
   int          acc_cyc_q[$];
   int          rdy_err;
   int          busy_err;

   localparam int PH_LOAD  = 0;
   localparam int PH_WRITE = 1;
   localparam int PH_FIN   = 2;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic send_start(input logic [9:0] wc);
      start      = 1'b1;
      word_count = wc;
      tick();
      start      = 1'b0;
   endtask

   function automatic logic [31:0] model_word(input byte_q_t b, input int i);
      return 32'(b[4*i]) + (32'(b[4*i+1]) << 8) + (32'(b[4*i+2]) << 16) + (32'(b[4*i+3]) << 24);
   endfunction

   // Streams bytes and tracks, at word granularity, when the loader should be accepting.
   task automatic send_bytes(input byte_q_t bytes, input int n_words, input int gap_lo,
                             input int gap_hi, input int poke_at);
      int  k = 0;
      int  words = 0;
      int  gap_left = 0;
      int  phase = PH_LOAD;
      int  guard = 0;
      bit  acc;
      acc_cyc_q.delete();
      rdy_err  = 0;
      busy_err = 0;
      while (k < bytes.size() && guard < 2000) begin
         if (gap_left > 0) begin
            byte_valid = 1'b0;
            gap_left--;
         end else begin
            byte_valid = 1'b1;
            byte_data  = bytes[k];
         end
         if (poke_at == k && byte_valid) begin
            start      = 1'b1;
            word_count = 10'd7;
         end
         acc = byte_valid && (phase == PH_LOAD);
         tick();
         start = 1'b0;
         if (phase == PH_WRITE) begin
            phase = (words == n_words) ? PH_FIN : PH_LOAD;
         end else if (acc) begin
            k++;
            if (k % 4 == 0) begin
               phase = PH_WRITE;
               words++;
               acc_cyc_q.push_back(cyc);
            end
            gap_left = $urandom_range(gap_hi, gap_lo);
         end
         if (byte_ready !== (phase == PH_LOAD)) rdy_err++;
         if (busy !== (phase != PH_FIN) || cpu_hold !== busy) busy_err++;
         guard++;
      end
      byte_valid = 1'b0;
      if (guard >= 2000) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_bytes_timeout: actual %0d bytes sent required %0d", k, bytes.size());
      end
   endtask

   task automatic load_and_check(input string tag, input int n, input byte_q_t bytes,
                                 input int gap_lo, input int gap_hi, input int poke_at);
      int base = w_addr_q.size();
      int got;
      send_start(10'(n));
      check({tag, ".busy_at_start"}, {busy, cpu_hold, byte_ready}, 3'b111);
      check({tag, ".flags_at_start"}, {done, error}, 2'b00);
      send_bytes(bytes, n, gap_lo, gap_hi, poke_at);
      tick();
      check({tag, ".done"}, {done, busy, cpu_hold, byte_ready, wr_en}, 5'b10000);
      check({tag, ".ready_pattern_errs"}, rdy_err, 0);
      check({tag, ".busy_pattern_errs"}, busy_err, 0);
      got = w_addr_q.size() - base;
      check({tag, ".n_writes"}, got, n);
      for (int i = 0; i < n && i < got; i++) begin
         check($sformatf("%s.addr%0d", tag, i), w_addr_q[base+i], i);
         check($sformatf("%s.data%0d", tag, i), w_data_q[base+i], model_word(bytes, i));
         if (i < acc_cyc_q.size())
            check($sformatf("%s.latency%0d", tag, i), w_cyc_q[base+i], acc_cyc_q[i]);
      end
      for (int i = 0; i < n; i++) ref_mem[i] = model_word(bytes, i);
   endtask

   typedef struct {
      logic       rst;
      logic       start;
      logic [9:0] wc;
      logic       done;
      logic       error;
      logic       busy;
   } vec_t;

   vec_t    vecs[$];
   byte_q_t prog;
   byte_q_t rnd;

   initial begin
      int base;
      int b0;

      rst = 1'b1; start = 1'b0; word_count = 10'd0; byte_valid = 1'b0; byte_data = 8'd0;
      tick();

      vecs.push_back('{1'b1, 1'b0, 10'd0,    1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 10'd0,    1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 10'd0,    1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 10'd513,  1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 10'd0,    1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 10'd1023, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 10'd0,    1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 10'd600,  1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 10'd512,  1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 10'd5,    1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 10'd0,    1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 1'b1, 10'd1,    1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 10'd513,  1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 10'd1,    1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 10'd0,    1'b0, 1'b0, 1'b0});

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; start = vecs[i].start; word_count = vecs[i].wc;
         tick();
         rst = 1'b0; start = 1'b0;
         check($sformatf("vec%0d.done", i), done, vecs[i].done);
         check($sformatf("vec%0d.error", i), error, vecs[i].error);
         check($sformatf("vec%0d.busy", i), {busy, cpu_hold, byte_ready}, {3{vecs[i].busy}});
         check($sformatf("vec%0d.wr_en", i), wr_en, 1'b0);
      end

      prog = '{8'hb3, 8'h82, 8'h41, 8'h00, 8'h33, 8'h83, 8'h41, 8'h40};
      check("golden.word0", model_word(prog, 0), 32'h004182b3);
      check("golden.word1", model_word(prog, 1), 32'h40418333);

      do_reset();
      load_and_check("back_to_back", 2, prog, 0, 0, -1);
      load_and_check("gapped", 2, prog, 3, 3, -1);

      do_reset();
      base = w_addr_q.size();
      b0   = busy_cycles;
      send_start(10'd0);
      check("zero.done", {done, busy, error}, 3'b100);
      repeat (3) tick();
      check("zero.writes", w_addr_q.size() - base, 0);
      check("zero.busy_cycles", busy_cycles - b0, 0);

      send_start(10'd513);
      check("too_big.flags", {error, done, busy, byte_ready}, 4'b1000);
      load_and_check("after_error", 1, '{8'h13, 8'h05, 8'h10, 8'h00}, 0, 0, -1);

      base = w_addr_q.size();
      send_start(10'd3);
      send_bytes(prog[0:5], 3, 0, 0, -1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst.outputs", {wr_en, busy, done, error, byte_ready, cpu_hold}, 6'b0);
      check("mid_rst.writes", w_addr_q.size() - base, 1);
      ref_mem[0] = model_word(prog, 0);
      tick();
      check("mid_rst.no_late_write", w_addr_q.size() - base, 1);
      load_and_check("reload", 1, '{8'h6f, 8'h00, 8'h00, 8'h00}, 0, 0, -1);

      load_and_check("start_poke", 2, prog, 0, 1, 5);

      for (int it = 0; it < 20; it++) begin
         int n = $urandom_range(5, 1);
         rnd.delete();
         for (int j = 0; j < 4 * n; j++) rnd.push_back(8'($urandom));
         load_and_check($sformatf("rand%0d", it), n, rnd, 0, $urandom_range(3, 0), -1);
      end

      check("imem.words_written", imem.size(), ref_mem.size());
      foreach (ref_mem[k]) begin
         check($sformatf("imem[%0d]", k), imem.exists(k) ? imem[k] : 32'hx, ref_mem[k]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles bytes little-endian into 32-bit instruction words.
- Issues one-cycle word writes into the instruction memory write port and holds the CPU in reset while loading.
- Sits between the boot byte source (UART receiver or testbench) and the instruction memory, so programs are loaded at runtime instead of being hardcoded.

Parameters:
- addr_ins_width, 32: width of wr_addr; same meaning as the instruction memory address width.
- memory_width, 32: instruction word width; the byte-lane logic assumes 32.
- memory_height, 512: number of words in the instruction memory; the upper bound for word_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; sampled only in IDLE or DONE.
- word_count  in  10  number of words to load, 0..1023; sampled on accepted start.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction memory write strobe.
- wr_addr  out  addr_ins_width  word index, identical indexing to the instruction memory read address.
- wr_data  out  32  assembled instruction word.
- busy  out  1  load in progress.
- done  out  1  load completed.
- error  out  1  last start was rejected.
- cpu_hold  out  1  keeps the core in reset; equal to busy.

Behaviour:
- Reset values: all outputs 0; state IDLE; byte counter, word index and assembly register 0. The reset is synchronous and active-high, and it wins over every other input in the same cycle.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE / DONE on start:
  - word_count == 0 -> DONE, no writes.
  - word_count > memory_height -> stay in or go to IDLE, error=1.
  - Otherwise latch word_count, clear word index, clear byte counter, error=0, done=0 -> LOAD.
- start in LOAD or WRITE is ignored.
- LOAD:
  - byte_ready=1.
  - A byte is accepted when byte_valid && byte_ready.
  - Byte k (k=0..3) is stored in wr_data bits [8k+7:8k]; the first byte goes to [7:0].
  - Byte counter increments modulo 4.
  - Accepting byte 3 -> WRITE on the next edge.
  - Cycles with byte_valid=0 change nothing.
- WRITE (exactly one cycle):
  - byte_ready=0, wr_en=1, wr_addr=current word index, wr_data=assembled word.
  - Next state: DONE if word index == latched count-1, otherwise LOAD with word index+1.
- Timing:
  - Write latency is 1 cycle after the 4th byte is accepted.
  - Maximum throughput is 1 word per 5 cycles.
- wr_en is 0 in every state except WRITE.
- wr_addr and wr_data hold their last values when wr_en=0; the bench must not check them then.
- busy=1 in LOAD and WRITE, otherwise 0.
- done=1 in DONE. DONE persists until start or rst.
- Reset mid-load: the partial word is discarded, no write is issued, and the block returns to IDLE with all outputs 0.
- Words beyond the last loaded one are untouched in memory.

Test Plan:
- Load word_count=2 with bytes b3 82 41 00 33 83 41 40, valid held high:
  - wr_en pulses twice: addr 0 data 0x004182b3, then addr 1 data 0x40418333.
  - Each pulse is 1 cycle after its 4th byte.
  - done=1 after the second write; busy and cpu_hold are high throughout.
- Same stream with byte_valid deasserted for 3 cycles between every byte -> identical writes, no extra wr_en, byte_ready stays 1 in LOAD.
- start with word_count=0 -> done=1 next cycle, wr_en never asserted, busy never high.
- start with word_count=513 -> error=1, state IDLE, byte_ready 0. A subsequent start with word_count=1 clears error and loads the word.
- Load word_count=3, assert rst after 6 bytes -> outputs all 0 next cycle. A new load of 1 word writes addr 0, not addr 1.
- Pulse start again during a 2-word load -> ignored; word index and count are unchanged and exactly 2 writes occur.
